// File: rtl/bpm_packet_framer.sv
// Frames each accepted FA position sample (X/Y/S plus clip flags and BPM index) into a
// four-word AXI-Stream packet for the Aurora link, and keeps link statistics.
module bpm_packet_framer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADC_COUNT      = 4,
  parameter int unsigned FOFB_IDX_WIDTH = 9
) (
  input  logic                      auroraUserClk,
  input  logic                      auroraUserReset,

  input  logic                      faStrobe,
  input  logic [DATA_WIDTH-1:0]     faX,
  input  logic [DATA_WIDTH-1:0]     faY,
  input  logic [DATA_WIDTH-1:0]     faS,
  input  logic [ADC_COUNT-1:0]      clippedAdc,
  input  logic [FOFB_IDX_WIDTH-1:0] fofbIndex,

  input  logic                      enable,
  input  logic                      channelUp,
  input  logic                      counterClear,

  output logic                      axisTxTvalid,
  output logic                      axisTxTlast,
  output logic [DATA_WIDTH-1:0]     axisTxTdata,
  input  logic                      axisTxTready,

  output logic [15:0]               packetCount,
  output logic [15:0]               overrunCount,
  output logic [15:0]               dropCount,
  output logic [15:0]               abortCount
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWx,
    StWy,
    StWs
  } state_e;

  state_e                    r_state;
  logic                      r_valid;
  logic                      r_last;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [7:0]                r_seq;

  logic [DATA_WIDTH-1:0]     r_x;
  logic [DATA_WIDTH-1:0]     r_y;
  logic [DATA_WIDTH-1:0]     r_s;
  logic [ADC_COUNT-1:0]      r_clip;
  logic [FOFB_IDX_WIDTH-1:0] r_idx;

  logic [15:0]               r_packet_cnt;
  logic [15:0]               r_overrun_cnt;
  logic [15:0]               r_drop_cnt;
  logic [15:0]               r_abort_cnt;

  logic                      w_busy;
  logic                      w_hs;
  logic                      w_accept;
  logic                      w_complete;
  logic                      w_abort;
  logic                      w_overrun;
  logic                      w_drop;
  logic [31:0]               w_header;

  // Header is built from the live inputs because the holding registers load on the same edge.
  assign w_header   = {8'hA5, r_seq, 4'(clippedAdc), 3'b000, 9'(fofbIndex)};

  assign w_busy     = (r_state != StIdle);
  assign w_hs       = r_valid & axisTxTready;
  assign w_accept   = ~w_busy & faStrobe & enable & channelUp;
  assign w_drop     = ~w_busy & faStrobe & ~(enable & channelUp);
  assign w_overrun  = w_busy & faStrobe;
  assign w_complete = (r_state == StWs) & w_hs;
  // A link drop on the final handshake still counts as a delivered packet.
  assign w_abort    = w_busy & ~channelUp & ~w_complete;

  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) begin
      r_state       <= StIdle;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_data        <= '0;
      r_seq         <= 8'd0;
      r_x           <= '0;
      r_y           <= '0;
      r_s           <= '0;
      r_clip        <= '0;
      r_idx         <= '0;
      r_packet_cnt  <= 16'd0;
      r_overrun_cnt <= 16'd0;
      r_drop_cnt    <= 16'd0;
      r_abort_cnt   <= 16'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_x     <= faX;
            r_y     <= faY;
            r_s     <= faS;
            r_clip  <= clippedAdc;
            r_idx   <= fofbIndex;
            r_state <= StHdr;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_data  <= DATA_WIDTH'(w_header);
          end
        end
        default: begin
          if (w_complete) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_seq   <= r_seq + 8'd1;
          end else if (!channelUp) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
          end else if (w_hs) begin
            case (r_state)
              StHdr: begin
                r_state <= StWx;
                r_data  <= r_x;
              end
              StWx: begin
                r_state <= StWy;
                r_data  <= r_y;
              end
              StWy: begin
                r_state <= StWs;
                r_data  <= r_s;
                r_last  <= 1'b1;
              end
              default: r_state <= StIdle;
            endcase
          end
        end
      endcase

      if (counterClear) begin
        r_packet_cnt  <= 16'd0;
        r_overrun_cnt <= 16'd0;
        r_drop_cnt    <= 16'd0;
        r_abort_cnt   <= 16'd0;
      end else begin
        if (w_complete) r_packet_cnt <= r_packet_cnt + 16'd1;
        if (w_overrun && (r_overrun_cnt != 16'hFFFF)) r_overrun_cnt <= r_overrun_cnt + 16'd1;
        if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        if (w_abort && (r_abort_cnt != 16'hFFFF)) r_abort_cnt <= r_abort_cnt + 16'd1;
      end
    end
  end

  assign axisTxTvalid = r_valid;
  assign axisTxTlast  = r_last;
  assign axisTxTdata  = r_data;
  assign packetCount  = r_packet_cnt;
  assign overrunCount = r_overrun_cnt;
  assign dropCount    = r_drop_cnt;
  assign abortCount   = r_abort_cnt;

endmodule

// File: tb/tb_bpm_packet_framer.sv
// Scoreboard bench for bpm_packet_framer: expected beats are queued when a sample is offered
// and compared as the framer hands them over on the AXI-Stream port.
module tb_bpm_packet_framer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fa_strobe;
  logic [DW-1:0] fa_x, fa_y, fa_s;
  logic [3:0]    clip;
  logic [8:0]    idx;
  logic          enable, channel_up, counter_clear, tready;
  logic          tvalid, tlast;
  logic [DW-1:0] tdata;
  logic [15:0]   pkt_cnt, ovr_cnt, drop_cnt, abort_cnt;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       sb_q[$];
  beat_t       mon_b;
  int          n_pass    = 0;
  int          n_total   = 0;
  int          exp_pkts  = 0;
  int          beats     = 0;
  logic [7:0]  exp_seq   = 8'd0;
  logic [7:0]  seq_mark;
  int          beats_mark;

  always #5 clk = ~clk;

  bpm_packet_framer #(
    .DATA_WIDTH    (DW),
    .ADC_COUNT     (4),
    .FOFB_IDX_WIDTH(9)
  ) dut (
    .auroraUserClk  (clk),
    .auroraUserReset(rst),
    .faStrobe       (fa_strobe),
    .faX            (fa_x),
    .faY            (fa_y),
    .faS            (fa_s),
    .clippedAdc     (clip),
    .fofbIndex      (idx),
    .enable         (enable),
    .channelUp      (channel_up),
    .counterClear   (counter_clear),
    .axisTxTvalid   (tvalid),
    .axisTxTlast    (tlast),
    .axisTxTdata    (tdata),
    .axisTxTready   (tready),
    .packetCount    (pkt_cnt),
    .overrunCount   (ovr_cnt),
    .dropCount      (drop_cnt),
    .abortCount     (abort_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] seq, input logic [3:0] c,
                                      input logic [8:0] i);
    return {8'hA5, seq, c, 3'b000, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] x, input logic [31:0] y, input logic [31:0] s,
                        input logic [3:0] c, input logic [8:0] i, input logic accept);
    fa_x = x; fa_y = y; fa_s = s; clip = c; idx = i;
    fa_strobe = 1'b1;
    if (accept) begin
      sb_q.push_back('{data: hdr(exp_seq, c, i), last: 1'b0});
      sb_q.push_back('{data: x, last: 1'b0});
      sb_q.push_back('{data: y, last: 1'b0});
      sb_q.push_back('{data: s, last: 1'b1});
    end
    tick();
    fa_strobe = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    check("drain", 32'(sb_q.size()), 32'd0);
    check("idle_after_drain", 32'(tvalid), 32'd0);
  endtask

  task automatic strobe_rand();
    strobe($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)),
           1'b1);
  endtask

  // Output monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (sb_q.size() == 0) begin
        check("beat_expected", 32'd0, 32'd1);
      end else begin
        mon_b = sb_q.pop_front();
        check("beat_data", tdata, mon_b.data);
        check("beat_last", 32'(tlast), 32'(mon_b.last));
        beats++;
        if (mon_b.last) begin
          exp_seq  = exp_seq + 8'd1;
          exp_pkts = exp_pkts + 1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; fa_strobe = 1'b0; fa_x = '0; fa_y = '0; fa_s = '0; clip = '0; idx = '0;
    enable = 1'b1; channel_up = 1'b1; counter_clear = 1'b0; tready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(tvalid), 32'd0);
    check("rst_last", 32'(tlast), 32'd0);
    check("rst_data", tdata, 32'd0);
    check("rst_counters", {pkt_cnt | ovr_cnt, drop_cnt | abort_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic packet
    strobe(32'd1, 32'd2, 32'd3, 4'b0101, 9'd37, 1'b1);
    check("basic_latency_valid", 32'(tvalid), 32'd1);
    check("basic_header", tdata, 32'hA5005025);
    drain();
    check("basic_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Backpressure held in WX
    beats_mark = beats;
    strobe(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 4'hF, 9'd511, 1'b1);
    check("bp_header_seq1", tdata, hdr(8'd1, 4'hF, 9'd511));
    tick();
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(tvalid), 32'd1);
      check("bp_hold_data", tdata, 32'h1111_0000);
      check("bp_hold_last", 32'(tlast), 32'd0);
    end
    tready = 1'b1;
    drain();
    check("bp_handshakes", 32'(beats - beats_mark), 32'd4);

    // Overrun while stalled, then overrun coincident with the final handshake
    tready = 1'b0;
    strobe(32'hA, 32'hB, 32'hC, 4'h1, 9'd2, 1'b1);
    tick();
    strobe(32'hDEAD, 32'hBEEF, 32'hCAFE, 4'h2, 9'd3, 1'b0);
    check("ovr_count1", 32'(ovr_cnt), 32'd1);
    check("ovr_hdr_intact", tdata, hdr(8'd2, 4'h1, 9'd2));
    tready = 1'b1;
    repeat (3) tick();
    check("ovr_in_ws_last", 32'(tlast), 32'd1);
    fa_strobe = 1'b1;
    tick();
    fa_strobe = 1'b0;
    check("ovr_count2", 32'(ovr_cnt), 32'd2);
    check("ovr_ws_idle", 32'(tvalid), 32'd0);
    check("ovr_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
    tick();
    check("ovr_sample_not_sent", 32'(tvalid), 32'd0);

    // Link loss in WY, then drops
    strobe(32'h51, 32'h52, 32'h53, 4'h3, 9'd100, 1'b1);
    repeat (2) tick();
    channel_up = 1'b0;
    tready = 1'b0;
    tick();
    check("abort_valid", 32'(tvalid), 32'd0);
    check("abort_count", 32'(abort_cnt), 32'd1);
    check("abort_pkt_cnt", 32'(pkt_cnt), 32'd3);
    check("abort_pending_beats", 32'(sb_q.size()), 32'd2);
    sb_q.delete();
    strobe(32'h61, 32'h62, 32'h63, 4'h0, 9'd1, 1'b0);
    check("drop_link_down", 32'(drop_cnt), 32'd1);
    channel_up = 1'b1;
    enable = 1'b0;
    strobe(32'h71, 32'h72, 32'h73, 4'h0, 9'd1, 1'b0);
    check("drop_disabled", 32'(drop_cnt), 32'd2);
    check("drop_not_sent", 32'(tvalid), 32'd0);
    enable = 1'b1;
    tready = 1'b1;
    strobe(32'h81, 32'h82, 32'h83, 4'h4, 9'd4, 1'b1);
    enable = 1'b0;
    drain();
    enable = 1'b1;
    check("enable_low_completes", 32'(pkt_cnt), 32'd4);
    check("enable_low_no_abort", 32'(abort_cnt), 32'd1);

    // Overrun saturation, clear priority, sequence wrap
    tready = 1'b0;
    strobe_rand();
    fa_strobe = 1'b1;
    repeat (70000) tick();
    fa_strobe = 1'b0;
    check("ovr_saturated", 32'(ovr_cnt), 32'hFFFF);
    counter_clear = 1'b1;
    fa_strobe = 1'b1;
    tick();
    counter_clear = 1'b0;
    fa_strobe = 1'b0;
    check("clear_ovr", 32'(ovr_cnt), 32'd0);
    check("clear_others", {pkt_cnt | drop_cnt, abort_cnt}, 32'd0);
    check("clear_keeps_packet", 32'(tvalid), 32'd1);
    exp_pkts = 0;
    tready = 1'b1;
    drain();
    seq_mark = exp_seq;
    for (int n = 0; n < 256; n++) begin
      strobe_rand();
      drain();
    end
    check("wrap_pkt_cnt", 32'(pkt_cnt), 32'd257);
    strobe(32'h91, 32'h92, 32'h93, 4'h6, 9'd6, 1'b1);
    check("wrap_seq_header", tdata, hdr(seq_mark, 4'h6, 9'd6));
    drain();

    // Reset mid-packet
    strobe(32'hA1, 32'hA2, 32'hA3, 4'h7, 9'd7, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(tvalid), 32'd0);
    check("rst_mid_counters", {pkt_cnt | ovr_cnt, drop_cnt | abort_cnt}, 32'd0);
    sb_q.delete();
    exp_seq = 8'd0;
    exp_pkts = 0;
    rst = 1'b0;
    tick();
    strobe(32'hB1, 32'hB2, 32'hB3, 4'h8, 9'd8, 1'b1);
    check("rst_seq0_header", tdata, hdr(8'd0, 4'h8, 9'd8));
    drain();
    check("rst_then_pkt", 32'(pkt_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
